fm_mod: RTL and testbench
=========================

// Module: fm_mod
// PURPOSE
//  Baseband FM modulator; the transmit-side counterpart of the quadrature FM demodulator.
//  Pops signed audio samples from an input FIFO and scales each by GAIN into a phase increment.
//  Accumulates phase in a wrapping register and emits cos/sin of the new phase as I/Q.
//  Writes I and Q to two output FIFOs that feed the demod loopback/TX path.
// PARAMETERS
//  DATA_WIDTH  32          width of audio, I and Q words (signed)
//  BITS        10          fixed-point fraction bits (Q.BITS); unit amplitude = 1<<BITS = 1024
//  PHASE_W     16          phase accumulator width; 2^PHASE_W == one full turn (2*pi)
//  ITERS       12          CORDIC iterations
//  GAIN        32'h400     phase units per audio LSB, Q.BITS (0x400 = 1.0)
// PORTS
//  clock      in   1           system clock
//  reset      in   1           reset
//  in_dout    in   DATA_WIDTH  audio sample, signed, from input FIFO
//  in_empty   in   1           input FIFO empty
//  in_rd_en   out  1           input FIFO pop
//  I_din      out  DATA_WIDTH  in-phase output, signed Q.BITS
//  I_full     in   1           I FIFO full
//  I_wr_en    out  1           I FIFO push
//  Q_din      out  DATA_WIDTH  quadrature output, signed Q.BITS
//  Q_full     in   1           Q FIFO full
//  Q_wr_en    out  1           Q FIFO push
// BEHAVIOUR
//  - reset: reset, asynchronous, active-high; clock: clock, rising edge.
//  - Reset values: state=IDLE, phase=0, in_rd_en=0, I_wr_en=0, Q_wr_en=0, I_din=0, Q_din=0.
//  - FSM states and transitions:
//      IDLE  -> LOAD   when !in_empty. in_rd_en=1 for exactly one cycle.
//                      Same edge: phase <= phase + inc[PHASE_W-1:0], mod 2^PHASE_W wrap.
//      LOAD  -> ROT    one-cycle start pulse to the CORDIC with the updated phase.
//      ROT   -> WRITE  on CORDIC done; latch cos into the I register and sin into the Q register.
//      WRITE -> IDLE   when !I_full && !Q_full; I_wr_en=Q_wr_en=1 for one cycle.
//  - inc = DEQUANTIZE(GAIN*in_dout).
//      Product is computed 64-bit signed.
//      DEQUANTIZE is an arithmetic shift right by BITS, rounding toward zero: negatives add (1<<BITS)-1 before the shift.
//  - Latency: with rd_en in cycle t and outputs not full, wr_en is asserted in cycle t+ITERS+3.
//      No new pop happens before the write completes (throughput = 1 sample per ITERS+4 cycles).
//  - I/Q are written together, never one without the other.
//      If either FIFO is full, stay in WRITE with both wr_en=0.
//      I_din/Q_din are held stable until the push.
//  - I_din/Q_din are sign-extended CORDIC outputs.
//      Accuracy: |I - round(1024*cos(2*pi*phase/2^PHASE_W))| <= 3 LSB; same bound for Q with sin.
//  - CORDIC: quadrant fold.
//      Top 2 phase bits select the quadrant; the residual angle goes to rotation mode.
//      Start x=622 (0.60725*1024, gain-compensated), y=0.
//      Output swap/negate by quadrant.
//  - Reset mid-operation: immediate return to IDLE with phase=0.
//      An in-flight sample (already popped) is discarded; no partial write occurs.
//  - in_empty toggling while not in IDLE has no effect.
//      I_full/Q_full toggling outside WRITE has no effect.
// STRUCTURE
//  - fm_pkg:
//      BITS, QUANT_VAL, QUANTIZE/DEQUANTIZE functions.
//      state_t enum {IDLE, LOAD, ROT, WRITE}.
//      CORDIC atan table: ITERS entries in PHASE_W phase units (0x2000, 0x12E4, 0x09FB, ...).
//      CORDIC_K0 = 622.
//  - Sub-module cordic_rot (clock, reset, start, phase, done, cos_out, sin_out).
//      Iterative, one iteration per cycle.
//      done is a 1-cycle pulse ITERS+1 cycles after start; results stay valid until the next start.
//  - fm_mod contains the FSM, phase accumulator, gain multiply and output registers.
// TESTING
//  1. Reset, push 0 -> phase 0x0000.
//     One I/Q push with I=1024+-3, Q=0+-3; wr_en exactly ITERS+3 cycles after rd_en.
//  2. From reset, push 16384 -> phase 0x4000, I=0+-3, Q=1024+-3.
//     Push 16384 again -> phase 0x8000, I=-1024+-3, Q=0+-3.
//  3. Wrap: four pushes of 16384 -> phase back to 0x0000.
//     4th output I=1024+-3, Q=0+-3.
//  4. From reset, push -8192 -> phase 0xE000, I=724+-3, Q=-724+-3 (rounding toward zero verified).
//  5. Hold I_full=1 for 10 cycles in WRITE -> no wr_en, I_din/Q_din stable, no in_rd_en.
//     Release -> exactly one push on both FIFOs.
//  6. Assert reset during ROT -> all outputs 0 immediately, no push.
//     Next sample 0 yields I=1024+-3 (phase restarted at 0).

Source files
------------

// File: rtl/fm_mod_pkg.sv
// Shared types, constants and helpers for the baseband FM modulator.
//   - Default geometry (data width, fraction bits, phase width, CORDIC iterations).
//   - Fixed-point quantize/dequantize helpers.
//   - Controller state enum.
//   - CORDIC arctangent table in phase units (2^16 == one full turn).
package fm_mod_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned BITS       = 10;
  localparam int unsigned PHASE_W    = 16;
  localparam int unsigned ITERS      = 12;
  localparam int unsigned QUANT_VAL  = 1 << BITS;

  // 0.60725 * 1024: pre-compensates the CORDIC gain so unit amplitude lands on 1024.
  localparam int CORDIC_K0 = 622;

  typedef enum logic [1:0] {IDLE, LOAD, ROT, WRITE} state_t;

  function automatic logic signed [63:0] quantize(input logic signed [63:0] v,
                                                  input int unsigned frac);
    return v <<< frac;
  endfunction

  // Arithmetic shift right that rounds toward zero rather than toward -inf.
  function automatic logic signed [63:0] dequantize(input logic signed [63:0] v,
                                                    input int unsigned frac);
    logic signed [63:0] bias;
    bias = v[63] ? ((64'sd1 <<< frac) - 64'sd1) : 64'sd0;
    return (v + bias) >>> frac;
  endfunction

  // round(atan(2^-i) * 2^16 / (2*pi)); valid for 16-bit phase.
  function automatic logic [15:0] atan_lut(input logic [3:0] i);
    logic [15:0] a;
    unique case (i)
      4'd0:    a = 16'h2000;
      4'd1:    a = 16'h12E4;
      4'd2:    a = 16'h09FB;
      4'd3:    a = 16'h0511;
      4'd4:    a = 16'h028B;
      4'd5:    a = 16'h0146;
      4'd6:    a = 16'h00A3;
      4'd7:    a = 16'h0051;
      4'd8:    a = 16'h0029;
      4'd9:    a = 16'h0014;
      4'd10:   a = 16'h000A;
      4'd11:   a = 16'h0005;
      4'd12:   a = 16'h0003;
      4'd13:   a = 16'h0001;
      4'd14:   a = 16'h0001;
      default: a = 16'h0000;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/fm_mod_if.sv
// FIFO-side signal bundle of the FM modulator.
//   in_dout/in_empty/in_rd_en : input audio FIFO (first-word-fall-through)
//   I_din/I_full/I_wr_en      : in-phase output FIFO
//   Q_din/Q_full/Q_wr_en      : quadrature output FIFO
// master: the modulator side. slave: the FIFO side.
interface fm_mod_if #(
  parameter int unsigned DATA_WIDTH = fm_mod_pkg::DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] in_dout;
  logic                  in_empty;
  logic                  in_rd_en;
  logic [DATA_WIDTH-1:0] I_din;
  logic                  I_full;
  logic                  I_wr_en;
  logic [DATA_WIDTH-1:0] Q_din;
  logic                  Q_full;
  logic                  Q_wr_en;

  modport master (
    input  in_dout, in_empty, I_full, Q_full,
    output in_rd_en, I_din, I_wr_en, Q_din, Q_wr_en
  );

  modport slave (
    output in_dout, in_empty, I_full, Q_full,
    input  in_rd_en, I_din, I_wr_en, Q_din, Q_wr_en
  );

endinterface

// File: rtl/fm_mod_cordic_rot.sv
// Iterative rotation-mode CORDIC producing cos/sin of a wrapping phase.
//   clock, reset : clock, async active-high reset
//   start        : one-cycle pulse, captures phase
//   phase        : angle, 2^PHASE_W == one full turn
//   done         : one-cycle pulse ITERS+1 cycles after start
//   cos_out      : signed Q.10 cosine, valid from done until the next start
//   sin_out      : signed Q.10 sine, valid from done until the next start
// The top two phase bits pick the quadrant; the residual (0..90 deg) is rotated
// and the result swapped/negated back. Supports ITERS <= 16.
module fm_mod_cordic_rot #(
  parameter int unsigned PHASE_W = fm_mod_pkg::PHASE_W,
  parameter int unsigned ITERS   = fm_mod_pkg::ITERS,
  parameter int unsigned OUT_W   = fm_mod_pkg::DATA_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [PHASE_W-1:0] phase,
  output logic               done,
  output logic [OUT_W-1:0]   cos_out,
  output logic [OUT_W-1:0]   sin_out
);
  import fm_mod_pkg::*;

  // Extra fraction bits keep per-iteration shift truncation well under an output LSB.
  localparam int unsigned GUARD = 4;
  localparam int unsigned CW    = 20;
  localparam logic signed [CW-1:0] RND = CW'(1 << (GUARD - 1));

  logic signed [CW-1:0]      x_q, y_q;
  logic signed [PHASE_W-1:0] z_q;
  logic [1:0]                quad_q;
  logic [3:0]                cnt_q;
  logic                      busy_q, done_q;

  logic signed [CW-1:0]      x_sh, y_sh, x_rnd, y_rnd;
  logic signed [PHASE_W-1:0] atan;
  logic signed [OUT_W-1:0]   x_ext, y_ext;

  always_comb begin
    x_sh  = x_q >>> cnt_q;
    y_sh  = y_q >>> cnt_q;
    atan  = PHASE_W'(atan_lut(cnt_q));
    x_rnd = (x_q + RND) >>> GUARD;
    y_rnd = (y_q + RND) >>> GUARD;
    x_ext = {{(OUT_W - CW){x_rnd[CW-1]}}, x_rnd};
    y_ext = {{(OUT_W - CW){y_rnd[CW-1]}}, y_rnd};
  end

  // Undo the quadrant fold: rotating by +90 deg maps (c, s) -> (-s, c).
  always_comb begin
    cos_out = x_ext;
    sin_out = y_ext;
    unique case (quad_q)
      2'd0: begin cos_out = x_ext;  sin_out = y_ext;  end
      2'd1: begin cos_out = -y_ext; sin_out = x_ext;  end
      2'd2: begin cos_out = -x_ext; sin_out = -y_ext; end
      2'd3: begin cos_out = y_ext;  sin_out = -x_ext; end
    endcase
  end

  assign done = done_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      quad_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        x_q    <= CW'(CORDIC_K0 << GUARD);
        y_q    <= '0;
        z_q    <= {2'b00, phase[PHASE_W-3:0]};
        quad_q <= phase[PHASE_W-1 -: 2];
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        if (!z_q[PHASE_W-1]) begin
          x_q <= x_q - y_sh;
          y_q <= y_q + x_sh;
          z_q <= z_q - atan;
        end else begin
          x_q <= x_q + y_sh;
          y_q <= y_q - x_sh;
          z_q <= z_q + atan;
        end
        cnt_q <= cnt_q + 4'd1;
        if (cnt_q == 4'(ITERS - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fm_mod.sv
// Baseband FM modulator.
//   clock : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : fm_mod_if master -- pops signed audio from the input FIFO, pushes
//           signed Q.BITS I/Q pairs to the two output FIFOs.
// Each sample is scaled by GAIN into a phase increment, accumulated into a
// wrapping phase register, and the CORDIC's cos/sin of the new phase is written
// to I/Q. One sample every ITERS+4 cycles when the outputs are not full.
module fm_mod #(
  parameter int unsigned DATA_WIDTH = fm_mod_pkg::DATA_WIDTH,
  parameter int unsigned BITS       = fm_mod_pkg::BITS,
  parameter int unsigned PHASE_W    = fm_mod_pkg::PHASE_W,
  parameter int unsigned ITERS      = fm_mod_pkg::ITERS,
  parameter logic [31:0] GAIN       = 32'h400
) (
  input logic      clock,
  input logic      reset,
  fm_mod_if.master bus
);
  import fm_mod_pkg::*;

  state_t                state_q;
  logic [PHASE_W-1:0]    phase_q;
  logic                  rd_en_q;
  logic                  wr_en_q;
  logic [DATA_WIDTH-1:0] i_q, q_q;

  logic signed [63:0]    audio_ext, gain_ext, product, inc;
  logic [PHASE_W-1:0]    phase_next;

  logic                  cordic_start, cordic_done;
  logic [DATA_WIDTH-1:0] cordic_cos, cordic_sin;

  always_comb begin
    audio_ext  = {{(64 - DATA_WIDTH){bus.in_dout[DATA_WIDTH-1]}}, bus.in_dout};
    gain_ext   = {{32{GAIN[31]}}, GAIN};
    product    = audio_ext * gain_ext;
    inc        = dequantize(product, BITS);
    // Only the low PHASE_W bits matter: the accumulator wraps modulo one turn.
    phase_next = PHASE_W'(inc + 64'(phase_q));
  end

  assign cordic_start = (state_q == LOAD);

  fm_mod_cordic_rot #(
    .PHASE_W (PHASE_W),
    .ITERS   (ITERS),
    .OUT_W   (DATA_WIDTH)
  ) u_cordic (
    .clock   (clock),
    .reset   (reset),
    .start   (cordic_start),
    .phase   (phase_q),
    .done    (cordic_done),
    .cos_out (cordic_cos),
    .sin_out (cordic_sin)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      i_q     <= '0;
      q_q     <= '0;
    end else begin
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // FWFT input: in_dout is already the head word, so the pop and the
          // phase update share this edge.
          if (!bus.in_empty) begin
            rd_en_q <= 1'b1;
            phase_q <= phase_next;
            state_q <= LOAD;
          end
        end
        LOAD: state_q <= ROT;
        ROT: begin
          if (cordic_done) begin
            i_q     <= cordic_cos;
            q_q     <= cordic_sin;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          // Single push strobe keeps I and Q in lockstep.
          if (!bus.I_full && !bus.Q_full) begin
            wr_en_q <= 1'b1;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.in_rd_en = rd_en_q;
  assign bus.I_wr_en  = wr_en_q;
  assign bus.Q_wr_en  = wr_en_q;
  assign bus.I_din    = i_q;
  assign bus.Q_din    = q_q;

endmodule

// File: tb/tb_fm_mod.sv
module tb_fm_mod;

  localparam int unsigned ITERS = 12;
  localparam int          GAIN_I = 32'h400;
  localparam real         PI = 3.14159265358979;

  typedef struct {
    int i;
    int q;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  fm_mod_if #(.DATA_WIDTH(32)) bus ();

  fm_mod #(
    .DATA_WIDTH (32),
    .BITS       (10),
    .PHASE_W    (16),
    .ITERS      (ITERS),
    .GAIN       (32'h400)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  exp_t exp_q[$];
  int   in_fifo[$];
  int   rd_idx = 0;
  logic pop_pending = 1'b0;
  int   model_phase = 0;
  int   cyc = 0;
  int   rd_cyc = 0;
  int   pop_cnt = 0;
  int   wr_cnt = 0;
  logic lat_check = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  task automatic chk(input string tag, input int got, input int want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic chk_tol(input string tag, input int got, input int want, input int tol);
    n_tests++;
    assert (absdiff(got, want) <= tol) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d +-%0d", tag, got, want, tol);
    end
  endtask

  task automatic refresh_fifo();
    if (rd_idx < in_fifo.size()) begin
      bus.in_empty = 1'b0;
      bus.in_dout  = in_fifo[rd_idx];
    end else begin
      bus.in_empty = 1'b1;
      bus.in_dout  = '0;
    end
  endtask

  // Reference: rounding toward zero via integer division, then ideal cos/sin.
  task automatic push_sample(input int s);
    int   inc;
    real  ang;
    exp_t e;
    in_fifo.push_back(s);
    inc = int'((longint'(GAIN_I) * longint'(s)) / 64'sd1024);
    model_phase = (model_phase + inc) & 32'hFFFF;
    ang = 2.0 * PI * real'(model_phase) / 65536.0;
    e.i = int'(1024.0 * $cos(ang));
    e.q = int'(1024.0 * $sin(ang));
    exp_q.push_back(e);
    refresh_fifo();
  endtask

  // One clock: FIFO pop at the edge, then monitor/scoreboard at the falling edge.
  task automatic tick();
    exp_t e;
    @(posedge clock);
    if (pop_pending) begin
      rd_idx++;
      pop_pending = 1'b0;
    end
    cyc++;
    @(negedge clock);
    refresh_fifo();
    if (bus.I_wr_en || bus.Q_wr_en) begin
      chk("wr_pair", int'(bus.I_wr_en), int'(bus.Q_wr_en));
      chk("exp_avail", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk_tol("I_din", int'(bus.I_din), e.i, 3);
        chk_tol("Q_din", int'(bus.Q_din), e.q, 3);
        if (lat_check) chk("latency", cyc - rd_cyc, int'(ITERS) + 3);
      end
      wr_cnt++;
    end
    if (bus.in_rd_en) begin
      chk("pop_avail", int'(rd_idx < in_fifo.size()), 1);
      chk("pop_after_write", pop_cnt, wr_cnt);
      pop_cnt++;
      rd_cyc = cyc;
      pop_pending = 1'b1;
    end
  endtask

  task automatic wait_writes(input int target);
    int budget;
    budget = 400;
    while (wr_cnt < target && budget > 0) begin
      tick();
      budget--;
    end
    chk("wait_writes", int'(wr_cnt >= target), 1);
  endtask

  task automatic wait_pop(input int target);
    int budget;
    budget = 100;
    while (pop_cnt < target && budget > 0) begin
      tick();
      budget--;
    end
    chk("wait_pop", int'(pop_cnt >= target), 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_rd_en"}, int'(bus.in_rd_en), 0);
    chk({tag, "_I_wr_en"}, int'(bus.I_wr_en), 0);
    chk({tag, "_Q_wr_en"}, int'(bus.Q_wr_en), 0);
    chk({tag, "_I_din"}, int'(bus.I_din), 0);
    chk({tag, "_Q_din"}, int'(bus.Q_din), 0);
  endtask

  // Called at a falling edge with no unpopped input words pending.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1 check_zero_outputs("rst");
    exp_q.delete();
    model_phase = 0;
    tick();
    tick();
    pop_cnt = wr_cnt;
    reset = 1'b0;
  endtask

  initial begin
    int i0, q0, base;

    bus.in_empty = 1'b1;
    bus.in_dout  = '0;
    bus.I_full   = 1'b0;
    bus.Q_full   = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    check_zero_outputs("init");
    reset = 1'b0;

    // 1: sample 0 -> phase 0, I=1024 Q=0, latency checked by the monitor.
    push_sample(0);
    wait_writes(1);

    // 2: two quarter turns -> 0x4000 then 0x8000.
    do_reset();
    push_sample(16384);
    wait_writes(wr_cnt + 1);
    push_sample(16384);
    wait_writes(wr_cnt + 1);

    // 3: four back-to-back quarter turns wrap to 0x0000.
    do_reset();
    base = wr_cnt;
    push_sample(16384);
    push_sample(16384);
    push_sample(16384);
    push_sample(16384);
    wait_writes(base + 4);

    // 4: negative sample -> 0xE000, I=724 Q=-724.
    do_reset();
    push_sample(-8192);
    wait_writes(wr_cnt + 1);

    // 5: I FIFO full while in WRITE; a second sample waits in the input FIFO.
    lat_check = 1'b0;
    bus.I_full = 1'b1;
    base = wr_cnt;
    push_sample(0);
    push_sample(8192);
    wait_pop(pop_cnt + 1);
    repeat (ITERS + 3) tick();
    i0 = int'(bus.I_din);
    q0 = int'(bus.Q_din);
    chk_tol("held_I_value", i0, 724, 3);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("hold_I_wr_en", int'(bus.I_wr_en), 0);
      chk("hold_Q_wr_en", int'(bus.Q_wr_en), 0);
      chk("hold_rd_en", int'(bus.in_rd_en), 0);
      chk("hold_I_din", int'(bus.I_din), i0);
      chk("hold_Q_din", int'(bus.Q_din), q0);
    end
    bus.I_full = 1'b0;
    wait_writes(base + 1);
    repeat (3) tick();
    chk("single_push", wr_cnt, base + 1);
    wait_writes(base + 2);
    lat_check = 1'b1;

    // 6: reset while the CORDIC is rotating discards the in-flight sample.
    base = wr_cnt;
    push_sample(16384);
    wait_pop(pop_cnt + 1);
    repeat (3) tick();
    chk("pre_reset_I_din", int'(bus.I_din), 1024);
    do_reset();
    repeat (ITERS + 6) tick();
    chk("no_push_after_reset", wr_cnt, base);
    push_sample(0);
    wait_writes(base + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
